// File: rtl/fade_ramp_if.sv
// Control and status bundle between a channel controller and its fade_ramp
// phase generator.
interface fade_ramp_if #(
    parameter int unsigned RATE_W = 16,
    parameter int unsigned HOLD_W = 8
);
    logic              enable;
    logic              abort;
    logic              one_shot;
    logic [RATE_W-1:0] rate;
    logic [HOLD_W-1:0] hold_hi;
    logic [HOLD_W-1:0] hold_lo;
    logic [7:0]        phase;
    logic              phase_stb;
    logic              busy;
    logic              cycle_done;

    modport master (
        output enable, abort, one_shot, rate, hold_hi, hold_lo,
        input  phase, phase_stb, busy, cycle_done
    );

    modport slave (
        input  enable, abort, one_shot, rate, hold_hi, hold_lo,
        output phase, phase_stb, busy, cycle_done
    );
endinterface

// File: rtl/fade_ramp.sv
// Triangle phase generator (0->255->0) with prescaled stepping and dwell at
// peak and trough; feeds the sinusoid lookup of one LED channel.
module fade_ramp #(
    parameter int unsigned RATE_W = 16,
    parameter int unsigned HOLD_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    fade_ramp_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RISE, HOLD_HI, FALL, HOLD_LO} state_t;

    state_t            state_q, state_d;
    logic [7:0]        phase_q, phase_d;
    logic              phase_stb_q, phase_stb_d;
    logic              busy_q, busy_d;
    logic              cycle_done_q, cycle_done_d;
    logic [RATE_W-1:0] presc_q, presc_d;
    logic [RATE_W-1:0] rate_s_q, rate_s_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_hi_s_q, hold_hi_s_d;
    logic [HOLD_W-1:0] hold_lo_s_q, hold_lo_s_d;
    logic              tick;

    assign tick = (presc_q == rate_s_q);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        phase_stb_d  = 1'b0;
        cycle_done_d = 1'b0;
        hold_cnt_d   = hold_cnt_q;
        rate_s_d     = rate_s_q;
        hold_hi_s_d  = hold_hi_s_q;
        hold_lo_s_d  = hold_lo_s_q;
        presc_d      = (state_q == IDLE || tick) ? '0 : presc_q + 1'b1;

        if (state_q != IDLE && bus.abort) begin
            // Abort beats any tick this cycle; a strobe only if phase moves.
            state_d     = IDLE;
            phase_d     = '0;
            presc_d     = '0;
            phase_stb_d = (phase_q != 8'd0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable && !bus.abort) begin
                        state_d     = RISE;
                        rate_s_d    = bus.rate;
                        hold_hi_s_d = bus.hold_hi;
                        hold_lo_s_d = bus.hold_lo;
                    end
                end
                RISE: begin
                    if (tick) begin
                        phase_d     = phase_q + 8'd1;
                        phase_stb_d = 1'b1;
                        if (phase_q == 8'd254) begin
                            state_d    = HOLD_HI;
                            hold_cnt_d = '0;
                        end
                    end
                end
                HOLD_HI: begin
                    if (tick) begin
                        if (hold_cnt_q == hold_hi_s_q) begin
                            state_d = FALL;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                FALL: begin
                    if (tick) begin
                        phase_d     = phase_q - 8'd1;
                        phase_stb_d = 1'b1;
                        if (phase_q == 8'd1) begin
                            state_d    = HOLD_LO;
                            hold_cnt_d = '0;
                        end
                    end
                end
                HOLD_LO: begin
                    if (tick) begin
                        if (hold_cnt_q == hold_lo_s_q) begin
                            cycle_done_d = 1'b1;
                            // Wrap keeps the prescaler running; only shadows reload.
                            if (bus.enable && !bus.one_shot) begin
                                state_d     = RISE;
                                rate_s_d    = bus.rate;
                                hold_hi_s_d = bus.hold_hi;
                                hold_lo_s_d = bus.hold_lo;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            phase_stb_q  <= 1'b0;
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            presc_q      <= '0;
            hold_cnt_q   <= '0;
            rate_s_q     <= '0;
            hold_hi_s_q  <= '0;
            hold_lo_s_q  <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            phase_stb_q  <= phase_stb_d;
            busy_q       <= busy_d;
            cycle_done_q <= cycle_done_d;
            presc_q      <= presc_d;
            hold_cnt_q   <= hold_cnt_d;
            rate_s_q     <= rate_s_d;
            hold_hi_s_q  <= hold_hi_s_d;
            hold_lo_s_q  <= hold_lo_s_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.phase_stb  = phase_stb_q;
    assign bus.busy       = busy_q;
    assign bus.cycle_done = cycle_done_q;
endmodule

// File: tb/tb_fade_ramp.sv
// Bench for fade_ramp: expected strobes (phase, clock index) and cycle_done
// times are queued at stimulus time and matched as the DUT emits them.
module tb_fade_ramp;
    localparam int unsigned RATE_W = 16;
    localparam int unsigned HOLD_W = 8;

    typedef struct {
        logic [7:0]  ph;
        int unsigned cy;
    } ev_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    int unsigned stb_cnt;
    int unsigned done_cnt;
    int unsigned busy_fall_cyc;
    logic        busy_prev;
    ev_t         exp_q[$];
    int unsigned done_q[$];
    ev_t         mon_e;
    int unsigned mon_d;

    fade_ramp_if #(.RATE_W(RATE_W), .HOLD_W(HOLD_W)) bus ();

    fade_ramp #(.RATE_W(RATE_W), .HOLD_W(HOLD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: pops an expectation for every strobe and every cycle_done.
    initial busy_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.phase_stb === 1'b1) begin
                stb_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stb_unexpected: phase=%0d at clock %0d, required no strobe", bus.phase, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.phase !== mon_e.ph || cyc !== mon_e.cy) begin
                        errors++;
                        $display("FAIL stb_event: phase=%0d at clock %0d, required phase=%0d at clock %0d",
                                 bus.phase, cyc, mon_e.ph, mon_e.cy);
                    end
                end
            end
            if (bus.cycle_done === 1'b1) begin
                done_cnt++;
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: cycle_done at clock %0d, required none", cyc);
                end else begin
                    mon_d = done_q.pop_front();
                    if (cyc !== mon_d) begin
                        errors++;
                        $display("FAIL done_time: cycle_done at clock %0d, required clock %0d", cyc, mon_d);
                    end
                end
            end
            if (busy_prev && bus.busy === 1'b0) busy_fall_cyc = cyc;
            busy_prev = bus.busy;
        end
    end

    // Queue one full ramp whose tick 0 lands on clock `base`; returns the cycle_done clock.
    function automatic int unsigned push_cycle(input int unsigned base, input int unsigned t,
                                               input int unsigned hh, input int unsigned hl);
        int unsigned d;
        for (int k = 1; k <= 255; k++) exp_q.push_back('{8'(k), base + int'(k) * t});
        for (int v = 254; v >= 0; v--) exp_q.push_back('{8'(v), base + (511 + hh - int'(v)) * t});
        d = base + (512 + hh + hl) * t;
        done_q.push_back(d);
        return d;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [7:0] p, input int lim);
        int n = 0;
        while (bus.phase !== p && n < lim) begin
            step();
            n++;
        end
        if (bus.phase !== p) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: phase=%0d after %0d clocks, required %0d", bus.phase, lim, p);
        end
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (bus.busy !== 1'b0 && n < lim) begin
            step();
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%0b after %0d clocks, required 0", bus.busy, lim);
        end
    endtask

    task automatic setup(input logic os, input int unsigned r, input int unsigned hh, input int unsigned hl);
        bus.one_shot = os;
        bus.rate     = RATE_W'(r);
        bus.hold_hi  = HOLD_W'(hh);
        bus.hold_lo  = HOLD_W'(hl);
        exp_q.delete();
        done_q.delete();
        stb_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        setup(1'b1, 100, 0, 0);
        bus.enable = 1'b1;
        repeat (3) step();
        checks += 4;
        if (bus.phase !== 8'd0)      begin errors++; $display("FAIL reset_phase: got %0d, required 0", bus.phase); end
        if (bus.phase_stb !== 1'b0)  begin errors++; $display("FAIL reset_stb: got %0b, required 0", bus.phase_stb); end
        if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0b, required 0", bus.busy); end
        if (bus.cycle_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b, required 0", bus.cycle_done); end
        rst = 1'b0;
        step();
        checks += 2;
        if (bus.busy !== 1'b1)  begin errors++; $display("FAIL reset_release_busy: got %0b, required 1", bus.busy); end
        if (bus.phase !== 8'd0) begin errors++; $display("FAIL reset_release_phase: got %0d, required 0", bus.phase); end
        bus.abort = 1'b1;
        step();
        bus.abort  = 1'b0;
        bus.enable = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_abort_busy: got %0b, required 0", bus.busy); end
        step();
    endtask

    task automatic run_one_shot(input string nm, input int unsigned r, input int unsigned hh,
                                input int unsigned hl, input int unsigned n_stb);
        int unsigned d;
        bus.enable = 1'b1;
        d = push_cycle(cyc + 1, r + 1, hh, hl);
        step();
        bus.enable = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s_busy_rise: got %0b, required 1", nm, bus.busy); end
        wait_idle(int'(d - cyc) + 50);
        checks += 5;
        if (busy_fall_cyc !== d) begin errors++; $display("FAIL %s_busy_fall: clock %0d, required %0d", nm, busy_fall_cyc, d); end
        if (stb_cnt !== n_stb)   begin errors++; $display("FAIL %s_stb_count: got %0d, required %0d", nm, stb_cnt, n_stb); end
        if (done_cnt !== 1)      begin errors++; $display("FAIL %s_done_count: got %0d, required 1", nm, done_cnt); end
        if (exp_q.size() != 0)   begin errors++; $display("FAIL %s_pending: %0d strobes missing, required 0", nm, exp_q.size()); end
        if (bus.phase !== 8'd0)  begin errors++; $display("FAIL %s_end_phase: got %0d, required 0", nm, bus.phase); end
    endtask

    task automatic test_one_shot_fast();
        setup(1'b1, 0, 0, 0);
        run_one_shot("fast", 0, 0, 0, 510);
    endtask

    task automatic test_rate_hold();
        int unsigned t255, t254;
        setup(1'b1, 3, 2, 1);
        bus.enable = 1'b1;
        void'(push_cycle(cyc + 1, 4, 2, 1));
        step();
        bus.enable = 1'b0;
        wait_phase(8'd255, 2000);
        t255 = cyc;
        wait_phase(8'd254, 100);
        t254 = cyc;
        checks++;
        if (t254 - t255 !== 16) begin errors++; $display("FAIL peak_dwell: %0d clocks at 255, required 16", t254 - t255); end
        wait_idle(2500);
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rate_pending: %0d strobes missing, required 0", exp_q.size()); end
        if (done_cnt !== 1)    begin errors++; $display("FAIL rate_done_count: got %0d, required 1", done_cnt); end
    endtask

    task automatic test_continuous_latch();
        int unsigned d1, d2;
        setup(1'b0, 1, 0, 0);
        bus.enable = 1'b1;
        d1 = push_cycle(cyc + 1, 2, 0, 0);
        wait_phase(8'd100, 400);
        bus.rate = RATE_W'(4);
        d2 = push_cycle(d1, 5, 0, 0);
        repeat (d1 + 3 - cyc) step();
        bus.enable = 1'b0;
        wait_idle(3000);
        checks += 3;
        if (busy_fall_cyc !== d2) begin errors++; $display("FAIL cont_busy_fall: clock %0d, required %0d", busy_fall_cyc, d2); end
        if (done_cnt !== 2)       begin errors++; $display("FAIL cont_done_count: got %0d, required 2", done_cnt); end
        if (exp_q.size() != 0)    begin errors++; $display("FAIL cont_pending: %0d strobes missing, required 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        int unsigned base;
        setup(1'b1, 0, 0, 0);
        bus.enable = 1'b1;
        base = cyc + 1;
        for (int k = 1; k <= 100; k++) exp_q.push_back('{8'(k), base + k});
        step();
        bus.enable = 1'b0;
        wait_phase(8'd100, 200);
        bus.abort = 1'b1;
        exp_q.push_back('{8'd0, cyc + 1});
        step();
        bus.abort = 1'b0;
        checks += 5;
        if (bus.phase !== 8'd0)      begin errors++; $display("FAIL abort_phase: got %0d, required 0", bus.phase); end
        if (bus.phase_stb !== 1'b1)  begin errors++; $display("FAIL abort_stb: got %0b, required 1", bus.phase_stb); end
        if (bus.busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %0b, required 0", bus.busy); end
        if (bus.cycle_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b, required 0", bus.cycle_done); end
        if (exp_q.size() != 0)       begin errors++; $display("FAIL abort_pending: %0d strobes missing, required 0", exp_q.size()); end
        bus.abort  = 1'b1;
        bus.enable = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy: got %0b, required 0", bus.busy); end
        end
        bus.abort  = 1'b0;
        bus.enable = 1'b0;
        step();
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL abort_done_count: got %0d, required 0", done_cnt); end
    endtask

    task automatic test_graceful_stop();
        int unsigned d;
        setup(1'b0, 0, 1, 3);
        bus.enable = 1'b1;
        d = push_cycle(cyc + 1, 1, 1, 3);
        wait_phase(8'd255, 400);
        wait_phase(8'd50, 400);
        bus.enable = 1'b0;
        wait_idle(400);
        checks += 3;
        if (busy_fall_cyc !== d) begin errors++; $display("FAIL stop_busy_fall: clock %0d, required %0d", busy_fall_cyc, d); end
        if (done_cnt !== 1)      begin errors++; $display("FAIL stop_done_count: got %0d, required 1", done_cnt); end
        if (exp_q.size() != 0)   begin errors++; $display("FAIL stop_pending: %0d strobes missing, required 0", exp_q.size()); end
        repeat (5) step();
        checks += 2;
        if (bus.phase !== 8'd0) begin errors++; $display("FAIL stop_phase_hold: got %0d, required 0", bus.phase); end
        if (bus.busy !== 1'b0)  begin errors++; $display("FAIL stop_busy_hold: got %0b, required 0", bus.busy); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        stb_cnt       = 0;
        done_cnt      = 0;
        busy_fall_cyc = 0;
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.abort     = 1'b0;
        bus.one_shot  = 1'b1;
        bus.rate      = '0;
        bus.hold_hi   = '0;
        bus.hold_lo   = '0;
        test_reset();
        test_one_shot_fast();
        test_rate_hold();
        test_continuous_latch();
        test_abort();
        test_graceful_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
